// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared widths and FSM state type for the AES result serializer
package aes_stream_pkg;
    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int WORDS   = BLOCK_W / WORD_W;
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/aes_result_serializer_if.sv
// rtl/aes_result_serializer_if.sv - word stream handshake between serializer and sink
interface aes_result_serializer_if;
    import aes_stream_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/aes_block_fifo.sv
// rtl/aes_block_fifo.sv - DEPTH x WIDTH block FIFO with first-word-fall-through head
module aes_block_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/aes_result_serializer.sv
// rtl/aes_result_serializer.sv - captures AES result blocks and streams them MSW-first as words
module aes_result_serializer
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BLOCK_W-1:0]         blk_data,
    input  logic                       blk_finished,
    aes_result_serializer_if.master    stream,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    state_t               state_q, state_d;
    logic [BLOCK_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 fin_q;
    logic                 rise;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic [BLOCK_W-1:0]   head;
    logic                 last_word;

    assign rise      = blk_finished & ~fin_q;
    // A full FIFO still accepts the new block when the head leaves at the same edge.
    assign push      = rise & (~full | pop);
    assign drop      = rise & full & ~pop;
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    aes_block_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BLOCK_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (blk_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            fin_q <= blk_finished;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (stream.out_ready) begin
                    if (!last_word) begin
                        shift_d = shift_q << WORD_W;
                        idx_d   = idx_q + 1'b1;
                    end else if (!empty) begin
                        // Reload on the final handshake so blocks stream without a bubble.
                        pop     = 1'b1;
                        shift_d = head;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stream.out_valid = (state_q == SEND);
    assign stream.out_last  = (state_q == SEND) && last_word;
    assign stream.out_data  = (state_q == SEND) ? shift_q[BLOCK_W-1 -: WORD_W] : '0;
endmodule

// File: tb/tb_aes_result_serializer.sv
// tb/tb_aes_result_serializer.sv - directed, table-driven bench for aes_result_serializer
module tb_aes_result_serializer;
    typedef struct {
        logic [127:0] blk;
        logic [31:0]  w [4];
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] blk_data = '0;
    logic         blk_finished = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [2:0]   fifo_count;
    logic         overflow;

    aes_result_serializer_if sif();

    aes_result_serializer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_data     (blk_data),
        .blk_finished (blk_finished),
        .stream       (sif),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    vec_t vt [6];
    int exp_idx [$];
    logic [31:0] got_d [$];
    bit          got_l [$];
    int          got_c [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", sif.out_valid, 1'b1);
                check("stall_data", sif.out_data, prev_d);
                check("stall_last", sif.out_last, prev_l);
            end
            if (sif.out_valid && sif.out_ready) begin
                got_d.push_back(sif.out_data);
                got_l.push_back(sif.out_last);
                got_c.push_back(cyc);
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_d     = sif.out_data;
            prev_l     = sif.out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [127:0] d);
        blk_data     = d;
        blk_finished = 1'b1;
        pulse_cyc    = cyc;
        step();
        blk_finished = 1'b0;
        step();
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic wait_words(input int n, input int budget);
        int t = 0;
        while (got_d.size() < n && t < budget) begin
            step();
            t++;
        end
        repeat (8) step();
    endtask

    task automatic check_stream(input string tag, input int nblk, input bit gapless);
        int n;
        check({tag, "_count"}, got_d.size(), nblk * 4);
        n = (got_d.size() < nblk * 4) ? got_d.size() : nblk * 4;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_data%0d", tag, k), got_d[k], vt[exp_idx[k / 4]].w[k % 4]);
            check($sformatf("%s_last%0d", tag, k), got_l[k], (k % 4) == 3);
            if (gapless && k > 0)
                check($sformatf("%s_gap%0d", tag, k), got_c[k] - got_c[k - 1], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        int peak;
        vt[0].blk = 128'h00112233_44556677_8899aabb_ccddeeff;
        vt[0].w   = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        vt[1].blk = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        vt[1].w   = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        vt[2].blk = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        vt[2].w   = '{32'hffffffff, 32'h00000000, 32'ha5a5a5a5, 32'h5a5a5a5a};
        vt[3].blk = 128'h11111111_22222222_33333333_44444444;
        vt[3].w   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        vt[4].blk = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;
        vt[4].w   = '{32'h0f0f0f0f, 32'hf0f0f0f0, 32'h12345678, 32'h9abcdef0};
        vt[5].blk = 128'h80000000_00000001_7fffffff_fffffffe;
        vt[5].w   = '{32'h80000000, 32'h00000001, 32'h7fffffff, 32'hfffffffe};
        sif.out_ready = 1'b0;

        repeat (3) step();
        check("rst_valid", sif.out_valid, 1'b0);
        check("rst_data", sif.out_data, 32'h0);
        check("rst_last", sif.out_last, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        step();

        // T1: single block, latency and word order
        sif.out_ready = 1'b1;
        clear_got();
        exp_idx = '{0};
        pulse(vt[0].blk);
        wait_words(4, 50);
        check_stream("t1", 1, 1'b1);
        if (got_c.size() > 0) check("t1_latency", got_c[0] - pulse_cyc, 2);

        // T2: level held high captures once
        clear_got();
        exp_idx = '{1};
        peak = 0;
        blk_data = vt[1].blk;
        blk_finished = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        blk_finished = 1'b0;
        wait_words(4, 50);
        repeat (10) step();
        check_stream("t2", 1, 1'b1);
        check("t2_peak", peak, 1);

        // T3/T4: fill under back-pressure, drop, overflow clear, gapless drain
        sif.out_ready = 1'b0;
        clear_got();
        for (int i = 0; i < 5; i++) pulse(vt[i].blk);
        check("t3_count_full", fifo_count, 3'd4);
        check("t3_ovf_none", overflow, 1'b0);
        check("t3_head_valid", sif.out_valid, 1'b1);
        check("t3_head_data", sif.out_data, vt[0].w[0]);
        pulse(vt[5].blk);
        check("t3_ovf_set", overflow, 1'b1);
        check("t3_count_drop", fifo_count, 3'd4);
        blk_data = vt[5].blk;
        blk_finished = 1'b1;
        ovf_clr = 1'b1;
        step();
        check("t3_ovf_set_wins", overflow, 1'b1);
        blk_finished = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", overflow, 1'b0);
        exp_idx = '{0, 1, 2, 3, 4};
        sif.out_ready = 1'b1;
        wait_words(20, 100);
        check_stream("t4", 5, 1'b1);
        check("t4_count_empty", fifo_count, 3'd0);

        // T5: random back-pressure while blocks arrive
        clear_got();
        exp_idx = '{1, 2, 3, 4};
        fork
            begin
                for (int i = 1; i < 5; i++) pulse(vt[i].blk);
            end
            begin
                repeat (60) begin
                    step();
                    sif.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        sif.out_ready = 1'b1;
        wait_words(16, 200);
        check_stream("t5", 4, 1'b0);

        // T6: reset in the middle of a block
        clear_got();
        pulse(vt[2].blk);
        for (int t = 0; t < 20 && got_d.size() < 1; t++) step();
        check("t6_started", got_d.size(), 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", sif.out_valid, 1'b0);
        check("t6_data", sif.out_data, 32'h0);
        check("t6_last", sif.out_last, 1'b0);
        check("t6_count", fifo_count, 3'd0);
        repeat (2) step();
        rst_n = 1'b1;
        clear_got();
        step();
        exp_idx = '{3};
        pulse(vt[3].blk);
        wait_words(4, 50);
        check_stream("t6", 1, 1'b1);
        if (got_c.size() > 0) check("t6_latency", got_c[0] - pulse_cyc, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
